mod10_counter: RTL and testbench

- Single-digit BCD down-counter (0-9) used as one digit of the microwave cook-time countdown chain.
- Parallel-loadable from a 4-bit digit value.
- Counts down one step per enabled clock and wraps 0 -> 9.
- Produces a terminal-count (borrow) output to decrement the next-more-significant digit, plus a zero flag for end-of-time detection.

---
 rtl/mod10_counter.sv | 20 ++
 tb/tb_mod10_counter.sv | 87 ++++++++
 2 files changed

// File: rtl/mod10_counter.sv
// mod10_counter: loadable BCD down-counter digit with 0->9 wrap, borrow (tc) and zero flag
module mod10_counter (
  input  logic       clk,
  input  logic       clrn,
  input  logic [3:0] data,
  input  logic       loadn,
  input  logic       en,
  output logic [3:0] ones,
  output logic       tc,
  output logic       zero
);
  logic [3:0] nxt;
  always_comb
    nxt = !loadn ? (data > 4'd9 ? 4'd9 : data) : en ? (ones == 4'd0 ? 4'd9 : ones - 4'd1) : ones;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) ones <= 4'd0;
    else ones <= nxt;
  assign zero = ones == 4'd0;
  assign tc = en & zero;
endmodule

// File: tb/tb_mod10_counter.sv
// tb_mod10_counter: scoreboard bench with a decimal-arithmetic digit model
module tb_mod10_counter;
  logic clk = 1'b0, clrn, loadn, en;
  logic [3:0] data, ones;
  logic tc, zero;
  typedef struct packed {logic [3:0] o; logic t; logic z;} exp_t;
  exp_t q[$];
  event smp;
  int m = 0, checks = 0, fails = 0;
  mod10_counter dut (.clk(clk), .clrn(clrn), .data(data), .loadn(loadn), .en(en), .ones(ones), .tc(tc), .zero(zero));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic expect_now();
    q.push_back('{4'(m), en && m == 0, m == 0});
    -> smp;
  endtask
  task automatic cyc(input logic l, input logic [3:0] d, input logic e);
    loadn = l;
    data = d;
    en = e;
    @(posedge clk);
    if (clrn) m = !l ? (d > 9 ? 9 : int'(d)) : e ? (m + 9) % 10 : m;
    expect_now();
    @(negedge clk);
  endtask
  task automatic async_clear();
    #1 clrn = 1'b0;
    m = 0;
    expect_now();
    #2 clrn = 1'b1;
  endtask
  initial forever begin
    exp_t e;
    @(smp);
    #1;
    if (q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard_empty got=none want=entry");
    end else begin
      e = q.pop_front();
      chk("ones", ones, e.o);
      chk("tc", {3'b0, tc}, {3'b0, e.t});
      chk("zero", {3'b0, zero}, {3'b0, e.z});
    end
  end
  initial begin
    clrn = 1'b0;
    loadn = 1'b0;
    data = 4'd9;
    en = 1'b1;
    #2 expect_now();
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'd9, 1'b1);
    clrn = 1'b1;
    cyc(1'b0, 4'd9, 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b1, 4'd0, 1'b1);
    cyc(1'b0, 4'd5, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0);
    cyc(1'b1, 4'd0, 1'b0);
    cyc(1'b0, 4'd3, 1'b0);
    cyc(1'b0, 4'd7, 1'b1);
    cyc(1'b0, 4'hC, 1'b0);
    cyc(1'b0, 4'hF, 1'b1);
    cyc(1'b0, 4'd6, 1'b0);
    async_clear();
    cyc(1'b1, 4'd0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) async_clear();
      cyc($urandom_range(0, 4) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    #20;
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
